// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the MEM-stage data memory.
// Access sizes, FSM states and the wait-counter width.
package dmem_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic badShape(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        return (size == SZ_BAD)
            || (size == SZ_HALF && lane[0])
            || (size == SZ_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response handshake between the pipeline and dmem_stage.
// The pipeline side is master; the memory stage is slave.
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and
// extraction/extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wordOut,
    output logic [31:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        signFill;

    assign byteSel = rawWord[{lane, 3'b000} +: 8];
    assign halfSel = lane[1] ? rawWord[31:16] : rawWord[15:0];

    always_comb begin
        byteEn   = 4'b0000;
        wordOut  = wdata;
        loadData = '0;
        signFill = 1'b0;
        // Replicating the store data lets byteEn alone pick the lanes.
        unique case (1'b1)
            size == SZ_BYTE: begin
                byteEn   = 4'b0001 << lane;
                wordOut  = {4{wdata[7:0]}};
                signFill = ~isUnsigned & byteSel[7];
                loadData = {{24{signFill}}, byteSel};
            end
            size == SZ_HALF: begin
                byteEn   = lane[1] ? 4'b1100 : 4'b0011;
                wordOut  = {2{wdata[15:0]}};
                signFill = ~isUnsigned & halfSel[15];
                loadData = {{16{signFill}}, halfSel};
            end
            size == SZ_WORD: begin
                byteEn   = 4'b1111;
                loadData = rawWord;
            end
            default: begin
                byteEn = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_stage.sv
// dmem_stage: word-organised data RAM with byte/half/word access,
// valid/ready request handshake and configurable wait states.
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              readyQ;
    logic              respValid;
    logic              respErr;
    logic [31:0]       respRdata;

    logic              weQ;
    logic              unsQ;
    logic [1:0]        sizeQ;
    logic [31:0]       addrQ;
    logic [31:0]       wdataQ;

    logic [31:0]       mem [DEPTH];

    logic              idle;
    logic              accept;
    logic              commit;
    logic              curWe;
    logic              curUns;
    logic              curErr;
    logic [1:0]        curSize;
    logic [31:0]       curAddr;
    logic [31:0]       curWdata;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rawWord;
    logic [31:0]       wordOut;
    logic [31:0]       loadData;
    logic [3:0]        byteEn;

    assign idle   = state == IDLE;
    assign accept = idle & bus.req_valid & readyQ;
    assign commit = (accept && WAIT_CYCLES == 0)
                 || (state == WAIT && cnt == '0);

    // With no wait states the access uses the request as it arrives.
    assign curWe    = idle ? bus.req_we       : weQ;
    assign curUns   = idle ? bus.req_unsigned : unsQ;
    assign curSize  = idle ? bus.req_size     : sizeQ;
    assign curAddr  = idle ? bus.req_addr     : addrQ;
    assign curWdata = idle ? bus.req_wdata    : wdataQ;

    assign idx     = curAddr[ADDR_W+1:2];
    assign curErr  = badShape(curSize, curAddr[1:0])
                  || ((curAddr >> (ADDR_W + 2)) != 32'd0);
    assign rawWord = mem[idx];

    dmem_lane_align u_align (
        .size       (curSize),
        .isUnsigned (curUns),
        .lane       (curAddr[1:0]),
        .wdata      (curWdata),
        .rawWord    (rawWord),
        .byteEn     (byteEn),
        .wordOut    (wordOut),
        .loadData   (loadData)
    );

    always_ff @(posedge clk) begin
        if (rst_n && commit && curWe && !curErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[idx][8*i +: 8] <= wordOut[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            readyQ    <= 1'b1;
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respRdata <= '0;
            weQ       <= 1'b0;
            unsQ      <= 1'b0;
            sizeQ     <= SZ_BYTE;
            addrQ     <= '0;
            wdataQ    <= '0;
        end else begin
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respRdata <= '0;
            if (accept) begin
                weQ    <= bus.req_we;
                unsQ   <= bus.req_unsigned;
                sizeQ  <= bus.req_size;
                addrQ  <= bus.req_addr;
                wdataQ <= bus.req_wdata;
                readyQ <= 1'b0;
                cnt    <= CNT_INIT;
                state  <= WAIT;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                state     <= RESP;
                readyQ    <= 1'b0;
                respValid <= 1'b1;
                respErr   <= curErr;
                respRdata <= (curWe || curErr) ? '0 : loadData;
            end else if (state == RESP) begin
                state  <= IDLE;
                readyQ <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = readyQ;
    assign bus.resp_valid = respValid;
    assign bus.resp_err   = respErr;
    assign bus.resp_rdata = respRdata;

endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- Parametrised successor to the single-word data-memory stage: word-organised synchronous RAM with byte, halfword and word access.
- Loads are sign- or zero-extended; alignment and range errors are reported.
- Requests use a valid/ready handshake with a configurable number of wait states, so the pipeline can model slower memory.
- Sits in the MEM stage between the ALU result/store-data registers and the writeback mux.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2^ADDR_W words of 32 bits; byte address uses bits [ADDR_W+1:0].
- WAIT_CYCLES, 0, extra cycles between request acceptance and access commit (0..15).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1; ignored for word loads and stores
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores, errors, and when resp_valid=0
- resp_err  out  1  valid only with resp_valid: misaligned, illegal size, or out of range

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A handshake at edge k (req_valid & req_ready) latches we, size, unsigned, addr and wdata.
  - After the handshake, go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise perform the access at edge k and go to RESP.
  - WAIT: req_ready=0; counter decrements each edge. When it reaches 0, perform the access at that edge and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0; next edge returns to IDLE.
- Timing:
  - Access commits at edge k+WAIT_CYCLES; resp_valid is high in the following cycle.
  - Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Error detection at acceptance:
  - Error if size=11; half with addr[0]=1; word with addr[1:0]!=0; or any of addr[31:ADDR_W+2] nonzero.
  - Errored requests still traverse WAIT/RESP with the same latency.
  - Errored stores never modify memory; errored responses carry resp_err=1, rdata=0.
- Stores (word index = addr[ADDR_W+1:2]):
  - byte: wdata[7:0] into lane addr[1:0].
  - half: wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - word: all 4 lanes.
  - Other lanes are untouched.
- Loads:
  - Read data is registered at the commit edge.
  - The selected lane(s) are shifted to bit 0, then sign-extended unless req_unsigned=1.
- Read-after-write: a load accepted after a store has responded returns the new data; no overlap is possible.
- Reset mid-operation:
  - rst_n low in WAIT before the commit edge aborts the request; no memory write and no response.
  - Reset during RESP drops the pulse.
- Inputs are sampled only at the handshake edge; changes while busy are ignored.

Decomposition:
- Package dmem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, WAIT counter width constant (4).
- One natural sub-module, dmem_lane_align, which is combinational:
  - store path: 4-bit byte-enable and lane-shifted write word from size/addr[1:0]/wdata.
  - load path: extracted, extended read word from size/unsigned/addr[1:0]/raw word.
  - Top level holds the FSM, counter, registers and RAM array.

Test Plan:
- Word store/load, WAIT_CYCLES=0: store 0xDEADBEEF to 0x10 -> resp_valid one cycle after accept, err=0, rdata=0. Load word 0x10 -> rdata=0xDEADBEEF.
- Byte/half lanes:
  - Word 0 preset to 0x00000000; store byte 0x80 at 0x3 -> word 0 = 0x80000000.
  - Load byte 0x3 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
  - Store half 0x1234 at 0x0, then load word 0 -> 0x80001234.
- Errors:
  - Half load at 0x1 -> err=1, rdata=0.
  - Word store at 0x2 -> err=1, memory unchanged.
  - size=11 -> err=1.
  - Address 0x00001000 with ADDR_W=10 -> err=1.
- WAIT_CYCLES=3: req_ready low exactly 4 cycles after accept; resp_valid 4 cycles after the accept edge; back-to-back req_valid held high is accepted once every 5 cycles.
- Reset mid-op, WAIT_CYCLES=3: store 0xCAFEF00D to 0x20 aborted by rst_n low for one cycle after 1 wait cycle. Subsequent load 0x20 returns the prior value; no resp_valid from the aborted store.
- Wrap/depth: store to the last word 0xFFC returns err=0; load 0xFFC reads the value back. Store to 0x1000 errors and does not alias word 0.
